// File: rtl/nibble_serial_add_ctrl.sv
// Wide add/subtract sequencer that feeds an external 4-bit ripple-carry adder one nibble
// per clock and assembles the full-width result, carry-out and signed overflow flag.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 carry_out,
    output logic                 overflow,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_s,
    input  logic                 add_cout
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if (NIBBLES < 2) begin : g_paramCheck
        $error("nibble_serial_add_ctrl: NIBBLES must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       r_result;
    logic               r_carryOut;
    logic               r_overflow;
    logic [IDX_W+1:0]   w_bitBase;
    logic               w_lastNibble;

    assign w_bitBase    = {r_idx, 2'b00};
    assign w_lastNibble = (r_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // The adder inputs are only driven in RUN so the external adder sees quiet zeros otherwise.
    always_comb begin
        w_stateNext = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        add_a       = 4'h0;
        add_b       = 4'h0;
        add_cin     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                add_a   = r_a[w_bitBase +: 4];
                add_b   = r_b[w_bitBase +: 4];
                add_cin = r_carry;
                if (w_lastNibble) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Subtraction is A + ~B + 1: B is inverted at load time and the carry chain is seeded with sub.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_result   <= '0;
            r_carryOut <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= op_a;
                        r_b     <= op_b ^ {W{sub}};
                        r_carry <= sub;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_result[w_bitBase +: 4] <= add_s;
                    r_carry                  <= add_cout;
                    r_idx                    <= r_idx + 1'b1;
                    if (w_lastNibble) begin
                        r_carryOut <= add_cout;
                        r_overflow <= (r_a[W-1] == r_b[W-1]) && (add_s[3] != r_a[W-1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result    = r_result;
    assign carry_out = r_carryOut;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl: vector table with per-nibble adder checks,
// a done-driven scoreboard for results, and abort / ignored-start sequences.
module tb_nibble_serial_add_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_s;
    logic         add_cout;

    typedef struct {
        logic               sub;
        logic [W-1:0]       a;
        logic [W-1:0]       b;
        logic [W-1:0]       expResult;
        logic               expCarry;
        logic               expOvf;
        logic [NIBBLES-1:0] expCinSeq;
    } vec_t;

    localparam int NUM_VEC = 8;
    vec_t vectors[NUM_VEC];
    vec_t sbQueue[$];
    vec_t sbExp;
    int   total     = 0;
    int   bad       = 0;
    int   doneCount = 0;
    int   baseDone;

    always #5 clk = ~clk;

    // Exact 4-bit adder standing in for the external ripple-carry instance.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

    nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sub       (sub),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && done) begin
            doneCount++;
            if (sbQueue.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done: got done=1 expected no pending request");
            end else begin
                sbExp = sbQueue.pop_front();
                checkOutput("sb_result", result, sbExp.expResult);
                checkOutput("sb_carry_out", carry_out, sbExp.expCarry);
                checkOutput("sb_overflow", overflow, sbExp.expOvf);
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        logic [W-1:0] bEff;
        bEff = v.sub ? ~v.b : v.b;
        @(negedge clk);
        start = 1'b1;
        sub   = v.sub;
        op_a  = v.a;
        op_b  = v.b;
        sbQueue.push_back(v);
        @(negedge clk);
        start = 1'b0;
        sub   = 1'($urandom);
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        for (int i = 0; i < NIBBLES; i++) begin
            checkOutput("busy_run", busy, 1);
            checkOutput("done_early", done, 0);
            checkOutput($sformatf("add_a[%0d]", i), add_a, v.a[4*i +: 4]);
            checkOutput($sformatf("add_b[%0d]", i), add_b, bEff[4*i +: 4]);
            checkOutput($sformatf("add_cin[%0d]", i), add_cin, v.expCinSeq[i]);
            @(negedge clk);
        end
        checkOutput("done_latency", done, 1);
        checkOutput("busy_in_done", busy, 1);
        @(negedge clk);
        checkOutput("done_one_cycle", done, 0);
        checkOutput("busy_idle", busy, 0);
        checkOutput("result_held", result, v.expResult);
        checkOutput("add_a_idle", add_a, 0);
        checkOutput("add_cin_idle", add_cin, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vectors[0] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 4'b0000};
        vectors[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 4'b1110};
        vectors[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 4'b1110};
        vectors[3] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 4'b0001};
        vectors[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 4'b0001};
        vectors[5] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'b0000};
        vectors[6] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 4'b1111};
        vectors[7] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 4'b0000};

        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b1;
        op_a  = 16'hA5A5;
        op_b  = 16'h5A5A;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_result", result, 0);
        checkOutput("reset_carry_out", carry_out, 0);
        checkOutput("reset_overflow", overflow, 0);
        checkOutput("reset_add_a", add_a, 0);
        checkOutput("reset_add_b", add_b, 0);
        checkOutput("reset_add_cin", add_cin, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_add_b", add_b, 0);

        for (int v = 0; v < NUM_VEC; v++) begin
            applyStimulus(vectors[v]);
        end

        // Abort: reset lands in the second RUN cycle.
        @(negedge clk);
        start = 1'b1;
        sub   = 1'b0;
        op_a  = 16'h1111;
        op_b  = 16'h1111;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_result", result, 0);
        checkOutput("abort_carry_out", carry_out, 0);
        checkOutput("abort_add_cin", add_cin, 0);
        rst      = 1'b0;
        baseDone = doneCount;
        repeat (NIBBLES + 2) @(negedge clk);
        checkOutput("abort_no_done", doneCount, baseDone);

        // Start held high through RUN and DONE must not queue a second operation.
        baseDone = doneCount;
        @(negedge clk);
        start = 1'b1;
        sub   = 1'b0;
        op_a  = 16'h0F0F;
        op_b  = 16'h0101;
        sbQueue.push_back('{1'b0, 16'h0F0F, 16'h0101, 16'h1010, 1'b0, 1'b0, 4'b1010});
        for (int k = 1; k <= NIBBLES + 1; k++) begin
            @(negedge clk);
            start = 1'b1;
            sub   = 1'($urandom);
            op_a  = 16'hFFFF;
            op_b  = W'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        checkOutput("ignored_start_one_done", doneCount, baseDone + 1);
        checkOutput("ignored_start_busy", busy, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("ignored_start_result_held", result, 16'h1010);
            checkOutput("ignored_start_still_idle", busy, 0);
        end
        checkOutput("ignored_start_done_total", doneCount, baseDone + 1);

        applyStimulus(vectors[2]);
        repeat (2) @(negedge clk);
        checkOutput("scoreboard_empty", sbQueue.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
